board_io: RTL and testbench

BOARD_IO -- requirements
Module: board_io

---
 rtl/board_io_pkg.sv | 35 +++
 rtl/ps2_rx.sv | 92 +++++++++
 rtl/board_io.sv | 91 +++++++++
 tb/tb_board_io.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/board_io_pkg.sv
// Shared constants and helpers for the board_io slice.
//   FrameLen   - PS/2 samples per frame (start, 8 data, parity, stop)
//   SegBlank   - all-segments-off glyph (active-low)
//   hex_to_seg - 4-bit value to active-low seven-segment glyph
//                (bit7=a ... bit1=g, bit0=dp; dp always off)
package board_io_pkg;

  localparam int unsigned FrameLen = 11;
  localparam logic [7:0]  SegBlank = 8'hFF;

  function automatic logic [7:0] hex_to_seg(input logic [3:0] val);
    logic [7:0] seg;
    seg = SegBlank;
    unique case (val)
      4'h0: seg = 8'h03;
      4'h1: seg = 8'h9F;
      4'h2: seg = 8'h25;
      4'h3: seg = 8'h0D;
      4'h4: seg = 8'h99;
      4'h5: seg = 8'h49;
      4'h6: seg = 8'h41;
      4'h7: seg = 8'h1F;
      4'h8: seg = 8'h01;
      4'h9: seg = 8'h09;
      4'hA: seg = 8'h11;
      4'hB: seg = 8'hC1;
      4'hC: seg = 8'h63;
      4'hD: seg = 8'h85;
      4'hE: seg = 8'h61;
      4'hF: seg = 8'h71;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 keyboard receiver.
//   clk, rst   - system clock, asynchronous active-high reset
//   ps2_clk    - device clock (asynchronous to clk)
//   ps2_data   - device data (asynchronous to clk)
//   kbd_data   - last accepted scancode
//   kbd_valid  - one-cycle pulse coincident with a kbd_data update
// Optional: define BOARD_IO_PARITY_CHECK_EN to reject frames with bad odd parity;
// otherwise the parity bit is ignored.
module ps2_rx
  import board_io_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] kbd_data,
  output logic       kbd_valid
);

  localparam logic [3:0] LastBit = 4'(FrameLen - 1);

  logic       clk_s1_q, clk_s2_q, clk_hist_q;
  logic       dat_s1_q, dat_s2_q;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  // Holds the first 10 samples: [0]=start, [8:1]=D0..D7, [9]=parity.
  logic [9:0] shift_q, shift_d;
  logic [7:0] kbd_data_q, kbd_data_d;
  logic       kbd_valid_q, kbd_valid_d;
  logic       fall;
  logic       parity_ok;
  logic       frame_ok;

  assign fall = clk_hist_q & ~clk_s2_q;

`ifdef BOARD_IO_PARITY_CHECK_EN
  assign parity_ok = ^shift_q[9:1];
`else
  logic unused_parity;
  assign unused_parity = shift_q[9];
  assign parity_ok     = 1'b1;
`endif

  // Stop bit is the sample arriving on the current edge.
  assign frame_ok = ~shift_q[0] & dat_s2_q & parity_ok;

  always_comb begin
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    kbd_data_d  = kbd_data_q;
    kbd_valid_d = 1'b0;
    if (fall) begin
      if (bit_cnt_q == LastBit) begin
        bit_cnt_d = 4'd0;
        if (frame_ok) begin
          kbd_data_d  = shift_q[8:1];
          kbd_valid_d = 1'b1;
        end
      end else begin
        bit_cnt_d = bit_cnt_q + 4'd1;
        shift_d   = {dat_s2_q, shift_q[9:1]};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_s1_q    <= 1'b1;
      clk_s2_q    <= 1'b1;
      clk_hist_q  <= 1'b1;
      dat_s1_q    <= 1'b1;
      dat_s2_q    <= 1'b1;
      bit_cnt_q   <= 4'd0;
      shift_q     <= 10'd0;
      kbd_data_q  <= 8'd0;
      kbd_valid_q <= 1'b0;
    end else begin
      clk_s1_q    <= ps2_clk;
      clk_s2_q    <= clk_s1_q;
      clk_hist_q  <= clk_s2_q;
      dat_s1_q    <= ps2_data;
      dat_s2_q    <= dat_s1_q;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      kbd_data_q  <= kbd_data_d;
      kbd_valid_q <= kbd_valid_d;
    end
  end

  assign kbd_data  = kbd_data_q;
  assign kbd_valid = kbd_valid_q;

endmodule

// File: rtl/board_io.sv
// Board I/O top: LED ring, PS/2 keyboard receiver and seven-segment digits.
//   LED_DIV        - clk cycles per LED ring step (>= 2)
//   clk, rst       - system clock, asynchronous active-high reset
//   btn[4:0]       - push buttons (XORed into ring[4:0] on the LEDs)
//   sw[7:0]        - slide switches (shown on ledr[7:0])
//   ps2_clk/data   - PS/2 keyboard lines
//   ledr[15:0]     - {ring[7:5], ring[4:0]^btn, sw}
//   kbd_data/valid - last scancode and its update pulse
//   seg0..seg7     - active-low digits: scancode, frame count, then blanks
// Optional: BOARD_IO_PARITY_CHECK_EN enables parity checking in ps2_rx.
module board_io
  import board_io_pkg::*;
#(
  parameter int unsigned LED_DIV = 5000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  btn,
  input  logic [7:0]  sw,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [15:0] ledr,
  output logic [7:0]  kbd_data,
  output logic        kbd_valid,
  output logic [7:0]  seg0,
  output logic [7:0]  seg1,
  output logic [7:0]  seg2,
  output logic [7:0]  seg3,
  output logic [7:0]  seg4,
  output logic [7:0]  seg5,
  output logic [7:0]  seg6,
  output logic [7:0]  seg7
);

  localparam int unsigned DivW = $clog2(LED_DIV);
  localparam logic [DivW-1:0] DivLast = DivW'(LED_DIV - 1);

  logic [DivW-1:0] div_q, div_d;
  logic [7:0]      ring_q, ring_d;
  logic [7:0]      count_q, count_d;

  always_comb begin
    div_d  = div_q + DivW'(1);
    ring_d = ring_q;
    if (div_q == DivLast) begin
      div_d  = '0;
      ring_d = {ring_q[6:0], ring_q[7]};
    end
  end

  // kbd_valid is exactly one pulse per accepted frame.
  always_comb begin
    count_d = count_q;
    if (kbd_valid) begin
      count_d = count_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q   <= '0;
      ring_q  <= 8'h01;
      count_q <= 8'd0;
    end else begin
      div_q   <= div_d;
      ring_q  <= ring_d;
      count_q <= count_d;
    end
  end

  ps2_rx u_ps2_rx (
    .clk       (clk),
    .rst       (rst),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .kbd_data  (kbd_data),
    .kbd_valid (kbd_valid)
  );

  assign ledr = {ring_q[7:5], ring_q[4:0] ^ btn, sw};

  assign seg0 = hex_to_seg(kbd_data[3:0]);
  assign seg1 = hex_to_seg(kbd_data[7:4]);
  assign seg2 = hex_to_seg(count_q[3:0]);
  assign seg3 = hex_to_seg(count_q[7:4]);
  assign seg4 = SegBlank;
  assign seg5 = SegBlank;
  assign seg6 = SegBlank;
  assign seg7 = SegBlank;

endmodule

// File: tb/tb_board_io.sv
module tb_board_io;

  localparam int Half = 6;
  localparam int Idle = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  btn = 5'd0;
  logic [7:0]  sw = 8'hA5;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  logic [15:0] ledr;
  logic [7:0]  kbd_data;
  logic        kbd_valid;
  logic [7:0]  seg0, seg1, seg2, seg3, seg4, seg5, seg6, seg7;

  int total = 0;
  int bad = 0;
  int pulse_cnt = 0;
  int wide_cnt = 0;
  logic prev_v = 1'b0;

  board_io #(.LED_DIV(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .btn       (btn),
    .sw        (sw),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .ledr      (ledr),
    .kbd_data  (kbd_data),
    .kbd_valid (kbd_valid),
    .seg0      (seg0),
    .seg1      (seg1),
    .seg2      (seg2),
    .seg3      (seg3),
    .seg4      (seg4),
    .seg5      (seg5),
    .seg6      (seg6),
    .seg7      (seg7)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (kbd_valid === 1'b1) pulse_cnt++;
    if (kbd_valid === 1'b1 && prev_v === 1'b1) wide_cnt++;
    prev_v = kbd_valid;
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_data = bits[i];
      repeat (Half) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (Half) @(negedge clk);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    repeat (Idle) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par_flip, input logic stop);
    logic [10:0] bits;
    bits = {stop, (~^d) ^ par_flip, d, 1'b0};
    send_bits(bits, 11);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    btn = 5'd0;
    #1;
    total++;
    if (ledr !== 16'h01A5) begin
      bad++; $display("FAIL reset_ledr: got %h want %h", ledr, 16'h01A5);
    end
    btn = 5'b00011;
    #1;
    total++;
    if (ledr[12:8] !== 5'b00010 || ledr[15:13] !== 3'b000) begin
      bad++; $display("FAIL reset_btn_xor: got %h want %h", ledr[15:8], 8'h02);
    end
    btn = 5'd0;
    total++;
    if (kbd_data !== 8'h00 || kbd_valid !== 1'b0) begin
      bad++; $display("FAIL reset_kbd: got %h/%b want 00/0", kbd_data, kbd_valid);
    end
    total++;
    if ({seg0, seg1, seg2, seg3} !== 32'h03030303) begin
      bad++; $display("FAIL reset_seg0_3: got %h want 03030303", {seg0, seg1, seg2, seg3});
    end
    total++;
    if ({seg4, seg5, seg6, seg7} !== 32'hFFFFFFFF) begin
      bad++; $display("FAIL reset_seg4_7: got %h want FFFFFFFF", {seg4, seg5, seg6, seg7});
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_led();
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (ledr !== 16'h01A5) begin
      bad++; $display("FAIL led_3clk: got %h want 01A5", ledr);
    end
    @(posedge clk);
    #1;
    total++;
    if (ledr !== 16'h02A5) begin
      bad++; $display("FAIL led_4clk: got %h want 02A5", ledr);
    end
    repeat (24) @(posedge clk);
    #1;
    total++;
    if (ledr !== 16'h80A5) begin
      bad++; $display("FAIL led_28clk: got %h want 80A5", ledr);
    end
    btn = 5'b10101;
    #1;
    total++;
    if (ledr !== 16'h95A5) begin
      bad++; $display("FAIL led_btn_ring80: got %h want 95A5", ledr);
    end
    btn = 5'd0;
    repeat (4) @(posedge clk);
    #1;
    total++;
    if (ledr !== 16'h01A5) begin
      bad++; $display("FAIL led_32clk: got %h want 01A5", ledr);
    end
  endtask

  task automatic test_valid_frame();
    int p0;
    @(negedge clk);
    p0 = pulse_cnt;
    send_frame(8'h1C, 1'b0, 1'b1);
    total++;
    if (pulse_cnt - p0 !== 1) begin
      bad++; $display("FAIL valid_pulses: got %0d want 1", pulse_cnt - p0);
    end
    total++;
    if (kbd_data !== 8'h1C) begin
      bad++; $display("FAIL valid_data: got %h want 1C", kbd_data);
    end
    total++;
    if ({seg3, seg2, seg1, seg0} !== 32'h039F9F63) begin
      bad++; $display("FAIL valid_segs: got %h want 039F9F63", {seg3, seg2, seg1, seg0});
    end
  endtask

  task automatic test_bad_stop();
    int p0;
    p0 = pulse_cnt;
    send_frame(8'h55, 1'b0, 1'b0);
    total++;
    if (pulse_cnt - p0 !== 0 || kbd_data !== 8'h1C) begin
      bad++; $display("FAIL bad_stop: got %0d/%h want 0/1C", pulse_cnt - p0, kbd_data);
    end
    total++;
    if (seg2 !== 8'h9F) begin
      bad++; $display("FAIL bad_stop_count: got %h want 9F", seg2);
    end
    p0 = pulse_cnt;
    send_frame(8'hF0, 1'b0, 1'b1);
    total++;
    if (pulse_cnt - p0 !== 1 || kbd_data !== 8'hF0) begin
      bad++; $display("FAIL after_bad: got %0d/%h want 1/F0", pulse_cnt - p0, kbd_data);
    end
    total++;
    if ({seg3, seg2, seg1, seg0} !== 32'h03257103) begin
      bad++; $display("FAIL after_bad_segs: got %h want 03257103", {seg3, seg2, seg1, seg0});
    end
  endtask

  task automatic test_parity();
    int p0;
    int exp_p;
    logic [7:0] exp_d;
`ifdef BOARD_IO_PARITY_CHECK_EN
    exp_p = 0;
    exp_d = 8'hF0;
`else
    exp_p = 1;
    exp_d = 8'h1C;
`endif
    p0 = pulse_cnt;
    send_frame(8'h1C, 1'b1, 1'b1);
    total++;
    if (pulse_cnt - p0 !== exp_p || kbd_data !== exp_d) begin
      bad++;
      $display("FAIL parity: got %0d/%h want %0d/%h", pulse_cnt - p0, kbd_data, exp_p, exp_d);
    end
  endtask

  task automatic test_mid_reset();
    int p0;
    logic [10:0] bits;
    bits = {1'b1, 1'b1, 8'hFF, 1'b0};
    send_bits(bits, 5);
    do_reset();
    repeat (4) @(negedge clk);
    p0 = pulse_cnt;
    send_frame(8'h2A, 1'b0, 1'b1);
    total++;
    if (pulse_cnt - p0 !== 1 || kbd_data !== 8'h2A) begin
      bad++; $display("FAIL mid_reset: got %0d/%h want 1/2A", pulse_cnt - p0, kbd_data);
    end
    total++;
    if ({seg3, seg2, seg1, seg0} !== 32'h039F2511) begin
      bad++; $display("FAIL mid_reset_segs: got %h want 039F2511", {seg3, seg2, seg1, seg0});
    end
  endtask

  task automatic test_count_wrap();
    int p0;
    do_reset();
    repeat (4) @(negedge clk);
    p0 = pulse_cnt;
    for (int i = 0; i < 255; i++) begin
      send_frame(8'(i + 1), 1'b0, 1'b1);
    end
    total++;
    if ({seg3, seg2, seg1, seg0} !== 32'h71717171) begin
      bad++; $display("FAIL wrap_ff: got %h want 71717171", {seg3, seg2, seg1, seg0});
    end
    send_frame(8'h00, 1'b0, 1'b1);
    total++;
    if ({seg3, seg2, seg1, seg0} !== 32'h03030303) begin
      bad++; $display("FAIL wrap_00: got %h want 03030303", {seg3, seg2, seg1, seg0});
    end
    total++;
    if (pulse_cnt - p0 !== 256) begin
      bad++; $display("FAIL wrap_pulses: got %0d want 256", pulse_cnt - p0);
    end
  endtask

  task automatic test_pulse_width();
    total++;
    if (wide_cnt !== 0) begin
      bad++; $display("FAIL pulse_width: got %0d wide pulses want 0", wide_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_led();
    test_valid_frame();
    test_bad_stop();
    test_parity();
    test_mid_reset();
    test_count_wrap();
    test_pulse_width();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
